register_file_write_32way: RTL and testbench
============================================

REGISTER_FILE_WRITE_32WAY -- requirements
Module: register_file_write_32way

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of each register.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wr_valid, input, 1 bit: the write request is present.
REQ-005 SHALL have port wr_ready, output, 1 bit: the block can accept a request this cycle.
REQ-006 SHALL have port wr_addr, input, 5 bits: the target register index, 0..31.
REQ-007 SHALL have port wr_data, input, WIDTH bits: the byte data, or the low half of a word write.
REQ-008 SHALL have port wr_word, input, 1 bit: when 1, the request is a register-pair write.
REQ-009 SHALL have port wr_data_hi, input, WIDTH bits: the high half of a word write, written to wr_addr+1.
REQ-010 SHALL have port wr_done, output, 1 bit: a one-cycle pulse when a request fully completes.
REQ-011 SHALL have port wr_err, output, 1 bit: a one-cycle pulse when an illegal request is rejected.
REQ-012 SHALL have ports reg0..reg31, each an output of WIDTH bits: the current register contents, which feed the 32-way read mux.

Function
REQ-013 SHALL accept a request on a rising edge where wr_valid and wr_ready are both 1; no other edge accepts a request.
REQ-014 SHALL implement the states IDLE and WORD_HI; wr_ready SHALL be 1 in IDLE and 0 in WORD_HI.
REQ-015 SHALL, for a byte request accepted in IDLE, write wr_data to reg[wr_addr] on the accepting edge, stay in IDLE, and pulse wr_done in the following cycle.
REQ-016 SHALL, for a word request with an even wr_addr accepted in IDLE, write wr_data to reg[wr_addr], latch wr_data_hi and wr_addr+1, and move to WORD_HI.
REQ-017 SHALL, in WORD_HI, write the latched high data to the latched address on the next edge, return to IDLE, and pulse wr_done in the following cycle.
REQ-018 SHALL, for a word request with an odd wr_addr, write no register, pulse wr_err in the following cycle, and stay in IDLE.
REQ-019 SHALL make a written value visible on regN in the cycle after the writing edge, i.e. write latency is 1 cycle.
REQ-020 SHALL hold every register not addressed by a write at its previous value.
REQ-021 SHALL ignore wr_addr, wr_data, wr_word and wr_data_hi whenever no request is accepted.
REQ-022 SHALL sustain back-to-back byte requests at one per cycle.
REQ-023 SHALL sustain a word request at one per two cycles.
REQ-024 SHALL never assert wr_done and wr_err in the same cycle.

Reset
REQ-025 SHALL, while reset is 1 at an edge, clear reg0..reg31 to 0, enter IDLE, and clear wr_done, wr_err and the latched high data and address.
REQ-026 SHALL give reset priority over any accepted request or pending WORD_HI write; the pending high-byte write is discarded and no wr_done pulse follows.
REQ-027 SHALL drive wr_ready to 1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with macro REGFILE_WORD_WRITE_EN defined, implement word writes as REQ-016 to REQ-018 specify.
REQ-029 SHALL, without REGFILE_WORD_WRITE_EN, omit the WORD_HI state and the latches, treat every request as a byte write per REQ-015 regardless of wr_word, ignore wr_data_hi, tie wr_err to 0, and hold wr_ready at 1 outside reset.

Structure
REQ-030 SHALL take the following from a shared register-file package: the register count (32), the address width (5), and the state encoding (IDLE, WORD_HI).
REQ-031 SHALL place the 5-to-32 one-hot write-enable decoder in a sub-module named write_decoder_5to32, with inputs addr and en and a 32-bit one-hot output.

Verification
REQ-032 SHALL cover: reset, then byte write addr=5 data=8'hA5 -> reg5=8'hA5 one cycle later, all other registers 0, wr_done pulses once.
REQ-033 SHALL cover: word write addr=24 lo=8'h34 hi=8'h12 -> reg24=8'h34 after cycle 1, reg25=8'h12 after cycle 2, wr_ready=0 for exactly one cycle.
REQ-034 SHALL cover: word write addr=7 -> wr_err pulses once, no register changes, wr_done stays 0.
REQ-035 SHALL cover: reset asserted in the WORD_HI cycle after a word write to addr=26 -> all registers 0 and no wr_done.
REQ-036 SHALL cover: byte writes to addresses 0..31 with data equal to the address on 32 consecutive cycles -> regN=N, wr_ready stays 1 throughout.
REQ-037 SHALL cover: REGFILE_WORD_WRITE_EN undefined, word request addr=10 lo=8'h55 -> reg10=8'h55, reg11 unchanged, wr_err=0.

Source files
------------

// File: rtl/register_file_write_32way_pkg.sv
// register_file_write_32way_pkg
// Shared definitions for the 32-entry register file write path.
//   NUM_REGS   : number of architectural registers (32)
//   ADDR_W     : register index width (5)
//   ST_IDLE    : write FSM accepting requests
//   ST_WORD_HI : write FSM committing the high half of a register-pair write
package register_file_write_32way_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WORD_HI = 1'b1;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_write_32way_decoder.sv
// write_decoder_5to32
// Turns a register index plus an enable into a one-hot per-register write enable.
//   addr   : register index, 0..31
//   en     : a write happens this edge
//   onehot : bit N set when register N is written; all zero when en is 0
module write_decoder_5to32
  import register_file_write_32way_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/register_file_write_32way.sv
// register_file_write_32way
// 32 x WIDTH register file write port with optional register-pair (word) writes.
// Optional feature macro: REGFILE_WORD_WRITE_EN enables word writes (even address
// pair, high half committed one cycle later) and the odd-address error pulse.
// Without it, every request is a byte write and wr_ready stays high.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   wr_valid / wr_ready  : request handshake, accepted when both are high
//   wr_addr, wr_data     : target index and data (low half for word writes)
//   wr_word, wr_data_hi  : word request flag and high half (goes to wr_addr+1)
//   wr_done, wr_err      : one-cycle completion / rejection pulses
//   reg0..reg31          : current register contents
module register_file_write_32way
  import register_file_write_32way_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_word,
  input  logic [WIDTH-1:0]  wr_data_hi,
  output logic              wr_done,
  output logic              wr_err,
  output logic [WIDTH-1:0]  reg0,  reg1,  reg2,  reg3,  reg4,  reg5,  reg6,  reg7,
  output logic [WIDTH-1:0]  reg8,  reg9,  reg10, reg11, reg12, reg13, reg14, reg15,
  output logic [WIDTH-1:0]  reg16, reg17, reg18, reg19, reg20, reg21, reg22, reg23,
  output logic [WIDTH-1:0]  reg24, reg25, reg26, reg27, reg28, reg29, reg30, reg31
);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                we_en;
  reg_addr_t           we_addr;
  logic [WIDTH-1:0]    we_data;
  logic [NUM_REGS-1:0] we_onehot;
  logic                accept;

  assign accept = wr_valid & wr_ready;

`ifdef REGFILE_WORD_WRITE_EN
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_data_q, hi_data_d;
  reg_addr_t        hi_addr_q, hi_addr_d;

  assign wr_ready = (state_q == ST_IDLE);

  // In IDLE the request's own address/data go to the write port; in WORD_HI
  // the port is reused for the latched high half, so only one write per edge.
  always_comb begin
    state_d   = state_q;
    hi_data_d = hi_data_q;
    hi_addr_d = hi_addr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    we_en     = 1'b0;
    we_addr   = wr_addr;
    we_data   = wr_data;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        if (!wr_word) begin
          we_en  = 1'b1;
          done_d = 1'b1;
        end else if (wr_addr[0]) begin
          // A pair must start on an even register; reject without writing.
          err_d = 1'b1;
        end else begin
          we_en     = 1'b1;
          hi_data_d = wr_data_hi;
          hi_addr_d = wr_addr + 1'b1;
          state_d   = ST_WORD_HI;
        end
      end
    end else begin
      we_en   = 1'b1;
      we_addr = hi_addr_q;
      we_data = hi_data_q;
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_data_q <= '0;
      hi_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_data_q <= hi_data_d;
      hi_addr_q <= hi_addr_d;
    end
  end
`else
  // Word requests are not supported in this build; the word inputs are don't-care.
  logic unused_word_inputs;
  assign unused_word_inputs = ^{wr_word, wr_data_hi};

  assign wr_ready = 1'b1;

  always_comb begin
    we_en   = accept;
    we_addr = wr_addr;
    we_data = wr_data;
    done_d  = accept;
    err_d   = 1'b0;
  end
`endif

  write_decoder_5to32 u_decoder (
    .addr   (we_addr),
    .en     (we_en),
    .onehot (we_onehot)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = we_onehot[i] ? we_data : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign wr_done = done_q;
  assign wr_err  = err_q;

  assign reg0  = regs_q[0];   assign reg1  = regs_q[1];
  assign reg2  = regs_q[2];   assign reg3  = regs_q[3];
  assign reg4  = regs_q[4];   assign reg5  = regs_q[5];
  assign reg6  = regs_q[6];   assign reg7  = regs_q[7];
  assign reg8  = regs_q[8];   assign reg9  = regs_q[9];
  assign reg10 = regs_q[10];  assign reg11 = regs_q[11];
  assign reg12 = regs_q[12];  assign reg13 = regs_q[13];
  assign reg14 = regs_q[14];  assign reg15 = regs_q[15];
  assign reg16 = regs_q[16];  assign reg17 = regs_q[17];
  assign reg18 = regs_q[18];  assign reg19 = regs_q[19];
  assign reg20 = regs_q[20];  assign reg21 = regs_q[21];
  assign reg22 = regs_q[22];  assign reg23 = regs_q[23];
  assign reg24 = regs_q[24];  assign reg25 = regs_q[25];
  assign reg26 = regs_q[26];  assign reg27 = regs_q[27];
  assign reg28 = regs_q[28];  assign reg29 = regs_q[29];
  assign reg30 = regs_q[30];  assign reg31 = regs_q[31];

endmodule

// File: tb/tb_register_file_write_32way.sv
// tb_register_file_write_32way
// Bench for register_file_write_32way: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the register file.
// Honours REGFILE_WORD_WRITE_EN the same way the design does.
module tb_register_file_write_32way;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         wr_word = 1'b0;
  logic [W-1:0] wr_data_hi = '0;
  wire          wr_ready, wr_done, wr_err;
  wire  [W-1:0] dut_regs [32];

  int checks_total  = 0;
  int checks_passed = 0;

  // Behavioural model: register contents, queued high-half writes, expected pulses.
  typedef struct { logic [4:0] a; logic [W-1:0] d; } wr_t;
  logic [W-1:0] m_regs [32];
  wr_t          m_pend [$];
  logic         m_done, m_err, m_ready;
  bit           model_valid = 0;

  register_file_write_32way #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_word(wr_word), .wr_data_hi(wr_data_hi),
    .wr_done(wr_done), .wr_err(wr_err),
    .reg0(dut_regs[0]),   .reg1(dut_regs[1]),   .reg2(dut_regs[2]),   .reg3(dut_regs[3]),
    .reg4(dut_regs[4]),   .reg5(dut_regs[5]),   .reg6(dut_regs[6]),   .reg7(dut_regs[7]),
    .reg8(dut_regs[8]),   .reg9(dut_regs[9]),   .reg10(dut_regs[10]), .reg11(dut_regs[11]),
    .reg12(dut_regs[12]), .reg13(dut_regs[13]), .reg14(dut_regs[14]), .reg15(dut_regs[15]),
    .reg16(dut_regs[16]), .reg17(dut_regs[17]), .reg18(dut_regs[18]), .reg19(dut_regs[19]),
    .reg20(dut_regs[20]), .reg21(dut_regs[21]), .reg22(dut_regs[22]), .reg23(dut_regs[23]),
    .reg24(dut_regs[24]), .reg25(dut_regs[25]), .reg26(dut_regs[26]), .reg27(dut_regs[27]),
    .reg28(dut_regs[28]), .reg29(dut_regs[29]), .reg30(dut_regs[30]), .reg31(dut_regs[31])
  );

  always #5 clk = ~clk;

  // Model update on each rising edge from the inputs the DUT sees at that edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      model_valid = 1;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_pend.size() > 0) begin
        m_regs[m_pend[0].a] = m_pend[0].d;
        m_pend.delete();
        m_done = 1'b1;
      end else if (wr_valid) begin
`ifdef REGFILE_WORD_WRITE_EN
        if (wr_word && (wr_addr % 2 == 1)) begin
          m_err = 1'b1;
        end else if (wr_word) begin
          m_regs[wr_addr] = wr_data;
          m_pend.push_back('{a: wr_addr + 5'd1, d: wr_data_hi});
        end else begin
          m_regs[wr_addr] = wr_data;
          m_done = 1'b1;
        end
`else
        m_regs[wr_addr] = wr_data;
        m_done = 1'b1;
`endif
      end
    end
    m_ready = (m_pend.size() == 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 32; i++) checkOutput($sformatf("cmp_reg%0d", i), 32'(dut_regs[i]), 32'(m_regs[i]));
      checkOutput("cmp_ready", 32'(wr_ready), 32'(m_ready));
      checkOutput("cmp_done", 32'(wr_done), 32'(m_done));
      checkOutput("cmp_err", 32'(wr_err), 32'(m_err));
      checkOutput("cmp_done_err_exclusive", 32'(wr_done & wr_err), 32'd0);
    end
  end

  // Drive one cycle of inputs, let the edge consume them, return 1 time unit later.
  task automatic applyStimulus(input bit rst, input bit valid, input logic [4:0] addr,
                               input logic [W-1:0] data, input bit word,
                               input logic [W-1:0] hi);
    reset      = rst;
    wr_valid   = valid;
    wr_addr    = addr;
    wr_data    = data;
    wr_word    = word;
    wr_data_hi = hi;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 5'd0, '0, 0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 5'd0, '0, 0, '0);
    applyStimulus(1, 0, 5'd0, '0, 0, '0);
  endtask

  function automatic int countNonZeroExcept(input int skip_a, input int skip_b);
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (i != skip_a && i != skip_b && dut_regs[i] !== '0) n++;
    return n;
  endfunction

  initial begin
    int nz;
    #1;
    doReset();
    checkOutput("reset_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset_done", 32'(wr_done), 32'd0);
    checkOutput("reset_nonzero_regs", countNonZeroExcept(-1, -1), 0);

    // Single byte write.
    applyStimulus(0, 1, 5'd5, 8'hA5, 0, 8'h00);
    checkOutput("byte_reg5", 32'(dut_regs[5]), 32'hA5);
    checkOutput("byte_done_pulse", 32'(wr_done), 32'd1);
    checkOutput("byte_others_zero", countNonZeroExcept(5, -1), 0);
    idleCycle();
    checkOutput("byte_done_once", 32'(wr_done), 32'd0);

`ifdef REGFILE_WORD_WRITE_EN
    // Word write to an even pair; a request held during WORD_HI must be ignored.
    doReset();
    applyStimulus(0, 1, 5'd24, 8'h34, 1, 8'h12);
    checkOutput("word_reg24", 32'(dut_regs[24]), 32'h34);
    checkOutput("word_reg25_pending", 32'(dut_regs[25]), 32'h00);
    checkOutput("word_ready_low", 32'(wr_ready), 32'd0);
    checkOutput("word_no_early_done", 32'(wr_done), 32'd0);
    applyStimulus(0, 1, 5'd3, 8'hFF, 0, 8'h00);
    checkOutput("word_reg25", 32'(dut_regs[25]), 32'h12);
    checkOutput("word_ready_back", 32'(wr_ready), 32'd1);
    checkOutput("word_done", 32'(wr_done), 32'd1);
    checkOutput("word_blocked_reg3", 32'(dut_regs[3]), 32'h00);
    idleCycle();

    // Odd-address word write is rejected.
    applyStimulus(0, 1, 5'd7, 8'h77, 1, 8'h88);
    checkOutput("odd_err", 32'(wr_err), 32'd1);
    checkOutput("odd_done", 32'(wr_done), 32'd0);
    checkOutput("odd_reg7", 32'(dut_regs[7]), 32'h00);
    checkOutput("odd_reg8", 32'(dut_regs[8]), 32'h00);
    idleCycle();
    checkOutput("odd_err_once", 32'(wr_err), 32'd0);

    // Reset during WORD_HI discards the pending high write.
    applyStimulus(0, 1, 5'd26, 8'h66, 1, 8'h99);
    applyStimulus(1, 0, 5'd0, '0, 0, '0);
    checkOutput("rst_hi_all_zero", countNonZeroExcept(-1, -1), 0);
    checkOutput("rst_hi_done", 32'(wr_done), 32'd0);
    idleCycle();
    checkOutput("rst_hi_done_after", 32'(wr_done), 32'd0);
    checkOutput("rst_hi_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_hi_reg27", 32'(dut_regs[27]), 32'h00);
`else
    // Word request treated as a plain byte write.
    doReset();
    applyStimulus(0, 1, 5'd10, 8'h55, 1, 8'hAA);
    checkOutput("noword_reg10", 32'(dut_regs[10]), 32'h55);
    checkOutput("noword_reg11", 32'(dut_regs[11]), 32'h00);
    checkOutput("noword_err", 32'(wr_err), 32'd0);
    checkOutput("noword_done", 32'(wr_done), 32'd1);
    checkOutput("noword_ready", 32'(wr_ready), 32'd1);
    applyStimulus(0, 1, 5'd7, 8'h3C, 1, 8'hC3);
    checkOutput("noword_odd_reg7", 32'(dut_regs[7]), 32'h3C);
    checkOutput("noword_odd_err", 32'(wr_err), 32'd0);
    idleCycle();
`endif

    // Back-to-back byte writes to every register.
    doReset();
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("b2b_ready_%0d", i), 32'(wr_ready), 32'd1);
      applyStimulus(0, 1, 5'(i), 8'(i), 0, 8'h00);
    end
    idleCycle();
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut_regs[i] !== 8'(i)) nz++;
    checkOutput("b2b_regN_eq_N", nz, 0);

    // Random traffic, checked by the per-cycle comparison.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    5'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    end
    idleCycle();
    idleCycle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
